// File: rtl/assoc_cache_pkg.sv
// Shared types and address helpers for the set-associative cache.
// Optional counters are enabled with ASSOC_CACHE_STATS_EN.
package assoc_cache_pkg;

   localparam int unsigned MAX_AW = 64;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_WRITEBACK = 3'd2,
      S_REFILL    = 3'd3,
      S_RESPOND   = 3'd4
   } cache_state_e;

   typedef struct packed {
      logic [31:0] hits;
      logic [31:0] misses;
      logic [31:0] evictions;
   } cache_stats_t;

   function automatic logic [MAX_AW-1:0] index_of(input logic [MAX_AW-1:0] addr,
                                                  input int unsigned off_w,
                                                  input int unsigned idx_w);
      logic [MAX_AW-1:0] mask;
      mask = (64'd1 << idx_w) - 64'd1;
      return (addr >> off_w) & mask;
   endfunction

   function automatic logic [MAX_AW-1:0] tag_of(input logic [MAX_AW-1:0] addr,
                                                input int unsigned off_w,
                                                input int unsigned idx_w);
      return addr >> (off_w + idx_w);
   endfunction

   function automatic logic [MAX_AW-1:0] line_addr(input logic [MAX_AW-1:0] tag,
                                                   input logic [MAX_AW-1:0] idx,
                                                   input int unsigned off_w,
                                                   input int unsigned idx_w);
      return (tag << (off_w + idx_w)) | (idx << off_w);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/assoc_cache_lru.sv
// Per-set true-LRU age array: accessed way becomes age 0, younger ways age by one.
module assoc_cache_lru #(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned SETS  = 64,
   parameter int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
   parameter int unsigned IDX_W = $clog2(SETS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IDX_W-1:0] set_idx,
   input  logic [WAY_W-1:0] acc_way,
   input  logic             upd,
   output logic [WAY_W-1:0] victim
);

   generate
      if (WAYS == 1) begin : g_single
         assign victim = '0;
      end else begin : g_lru
         logic [WAY_W-1:0] age_q [SETS][WAYS];
         logic [WAY_W-1:0] age_d [SETS][WAYS];
         logic [WAY_W-1:0] acc_age_s;
         logic [WAY_W-1:0] victim_s;

         // Age update for the accessed set
         always_comb begin
            age_d     = age_q;
            acc_age_s = age_q[set_idx][acc_way];
            if (upd) begin
               for (int w = 0; w < WAYS; w++) begin
                  age_d[set_idx][w] = (WAY_W'(w) == acc_way) ? '0 :
                                      (age_q[set_idx][w] < acc_age_s) ? age_q[set_idx][w] + WAY_W'(1) :
                                      age_q[set_idx][w];
               end
            end else begin
               age_d = age_q;
            end
         end

         // Oldest way of the selected set
         always_comb begin
            victim_s = '0;
            for (int w = 0; w < WAYS; w++) begin
               victim_s = (age_q[set_idx][w] == WAY_W'(WAYS - 1)) ? WAY_W'(w) : victim_s;
            end
         end

         assign victim = victim_s;

         // Age state; ages restart at the way index
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               for (int s = 0; s < SETS; s++) begin
                  for (int w = 0; w < WAYS; w++) begin
                     age_q[s][w] <= WAY_W'(w);
                  end
               end
            end else begin
               age_q <= age_d;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back/write-allocate cache, one outstanding request.
// Define ASSOC_CACHE_STATS_EN to add saturating hit/miss/eviction counters.
module assoc_cache #(
   parameter int unsigned DATAWIDTH    = 32,
   parameter int unsigned ADDRESSWIDTH = 32,
   parameter int unsigned WAYS         = 4,
   parameter int unsigned SETS         = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDRESSWIDTH-1:0] req_addr,
   input  logic [DATAWIDTH-1:0]    req_wdata,
   output logic                    rsp_valid,
   output logic [DATAWIDTH-1:0]    rsp_rdata,
   output logic                    mem_valid,
   input  logic                    mem_ready,
   output logic                    mem_write,
   output logic [ADDRESSWIDTH-1:0] mem_addr,
   output logic [DATAWIDTH-1:0]    mem_wdata,
   input  logic                    mem_rvalid,
   input  logic [DATAWIDTH-1:0]    mem_rdata
`ifdef ASSOC_CACHE_STATS_EN
   ,
   output logic [31:0]             stat_hits,
   output logic [31:0]             stat_misses,
   output logic [31:0]             stat_evictions
`endif
);
   import assoc_cache_pkg::*;

   localparam int unsigned OFF_W = $clog2(DATAWIDTH / 8);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = ADDRESSWIDTH - OFF_W - IDX_W;
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   cache_state_e            state_q, state_d;
   logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
   logic                    wr_q, wr_d;
   logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
   logic                    req_ready_q, req_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATAWIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic                    mem_valid_q, mem_valid_d;
   logic                    mem_write_q, mem_write_d;
   logic [ADDRESSWIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATAWIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic                    sent_q, sent_d;
   logic [WAY_W-1:0]        vict_q, vict_d;

   logic [WAYS-1:0]         valid_q [SETS];
   logic [WAYS-1:0]         valid_d [SETS];
   logic [WAYS-1:0]         dirty_q [SETS];
   logic [WAYS-1:0]         dirty_d [SETS];
   logic [TAG_W-1:0]        tag_q   [SETS][WAYS];
   logic [TAG_W-1:0]        tag_d   [SETS][WAYS];
   logic [DATAWIDTH-1:0]    data_q  [SETS][WAYS];
   logic [DATAWIDTH-1:0]    data_d  [SETS][WAYS];

   logic [IDX_W-1:0]        idx_s;
   logic [TAG_W-1:0]        tag_s;
   logic                    hit_s, inv_s, evict_s, install_s, lru_upd_s;
   logic [WAY_W-1:0]        hit_way_s, inv_way_s, lru_vict_s, vict_s, lru_way_s;
   logic [ADDRESSWIDTH-1:0] req_line_s, vict_line_s;

   assign idx_s       = IDX_W'(index_of(MAX_AW'(addr_q), OFF_W, IDX_W));
   assign tag_s       = TAG_W'(tag_of(MAX_AW'(addr_q), OFF_W, IDX_W));
   assign req_line_s  = ADDRESSWIDTH'(line_addr(MAX_AW'(tag_s), MAX_AW'(idx_s), OFF_W, IDX_W));
   assign vict_line_s = ADDRESSWIDTH'(line_addr(MAX_AW'(tag_q[idx_s][vict_s]), MAX_AW'(idx_s), OFF_W, IDX_W));

   // Parallel tag compare and lowest-numbered invalid way
   always_comb begin
      hit_s     = 1'b0;
      hit_way_s = '0;
      inv_s     = 1'b0;
      inv_way_s = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         hit_s     = hit_s | (valid_q[idx_s][w] & (tag_q[idx_s][w] == tag_s));
         hit_way_s = (valid_q[idx_s][w] & (tag_q[idx_s][w] == tag_s)) ? WAY_W'(w) : hit_way_s;
         inv_s     = inv_s | ~valid_q[idx_s][w];
         inv_way_s = valid_q[idx_s][w] ? inv_way_s : WAY_W'(w);
      end
   end

   assign vict_s    = inv_s ? inv_way_s : lru_vict_s;
   assign evict_s   = valid_q[idx_s][vict_s] & dirty_q[idx_s][vict_s];
   // Refill data may arrive together with the request acceptance
   assign install_s = (state_q == S_REFILL) && mem_rvalid && (sent_q || mem_ready);
   assign lru_upd_s = ((state_q == S_LOOKUP) && hit_s) || install_s;
   assign lru_way_s = (state_q == S_REFILL) ? vict_q : hit_way_s;

   assoc_cache_lru #(
      .WAYS  (WAYS),
      .SETS  (SETS),
      .WAY_W (WAY_W),
      .IDX_W (IDX_W)
   ) u_lru (
      .clock   (clock),
      .reset   (reset),
      .set_idx (idx_s),
      .acc_way (lru_way_s),
      .upd     (lru_upd_s),
      .victim  (lru_vict_s)
   );

   // Next-state and array update logic
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      mem_valid_d = mem_valid_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      sent_d      = sent_q;
      vict_d      = vict_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      tag_d       = tag_q;
      data_d      = data_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wr_d    = req_write;
               wdata_d = req_wdata;
               state_d = S_LOOKUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOOKUP: begin
            if (hit_s) begin
               if (wr_q) begin
                  data_d[idx_s][hit_way_s]  = wdata_q;
                  dirty_d[idx_s][hit_way_s] = 1'b1;
               end else begin
                  rsp_rdata_d = data_q[idx_s][hit_way_s];
               end
               rsp_valid_d = 1'b1;
               state_d     = S_RESPOND;
            end else begin
               vict_d      = vict_s;
               sent_d      = 1'b0;
               mem_valid_d = 1'b1;
               if (evict_s) begin
                  mem_write_d = 1'b1;
                  mem_addr_d  = vict_line_s;
                  mem_wdata_d = data_q[idx_s][vict_s];
                  state_d     = S_WRITEBACK;
               end else begin
                  mem_write_d = 1'b0;
                  mem_addr_d  = req_line_s;
                  state_d     = S_REFILL;
               end
            end
         end
         S_WRITEBACK: begin
            if (mem_ready) begin
               mem_write_d = 1'b0;
               mem_addr_d  = req_line_s;
               state_d     = S_REFILL;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_REFILL: begin
            if (mem_ready && !sent_q) begin
               sent_d      = 1'b1;
               mem_valid_d = 1'b0;
            end else begin
               sent_d = sent_q;
            end
            if (install_s) begin
               mem_valid_d            = 1'b0;
               valid_d[idx_s][vict_q] = 1'b1;
               tag_d[idx_s][vict_q]   = tag_s;
               if (wr_q) begin
                  data_d[idx_s][vict_q]  = wdata_q;
                  dirty_d[idx_s][vict_q] = 1'b1;
               end else begin
                  data_d[idx_s][vict_q]  = mem_rdata;
                  dirty_d[idx_s][vict_q] = 1'b0;
                  rsp_rdata_d            = mem_rdata;
               end
               rsp_valid_d = 1'b1;
               state_d     = S_RESPOND;
            end else begin
               state_d = S_REFILL;
            end
         end
         S_RESPOND: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      req_ready_d = (state_d == S_IDLE);
   end

   // Control state, registered outputs and valid/dirty bits
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         mem_valid_q <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         sent_q      <= 1'b0;
         vict_q      <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_valid_q <= mem_valid_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         sent_q      <= sent_d;
         vict_q      <= vict_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
      end
   end

   // Tag and data storage is not reset; valid bits guard it
   always_ff @(posedge clock) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_valid = mem_valid_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

`ifdef ASSOC_CACHE_STATS_EN
   cache_stats_t stats_q, stats_d;

   // Saturating event counters
   always_comb begin
      stats_d = stats_q;
      if (state_q == S_LOOKUP) begin
         if (hit_s) begin
            stats_d.hits = sat_inc(stats_q.hits);
         end else begin
            stats_d.misses = sat_inc(stats_q.misses);
            if (evict_s) begin
               stats_d.evictions = sat_inc(stats_q.evictions);
            end else begin
               stats_d.evictions = stats_q.evictions;
            end
         end
      end else begin
         stats_d = stats_q;
      end
   end

   // Counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stats_q <= '0;
      end else begin
         stats_q <= stats_d;
      end
   end

   assign stat_hits      = stats_q.hits;
   assign stat_misses    = stats_q.misses;
   assign stat_evictions = stats_q.evictions;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache configured as 2 ways x 16 sets, 32-bit.
// Counter checks are compiled in when ASSOC_CACHE_STATS_EN is defined.
module tb_assoc_cache;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
`ifdef ASSOC_CACHE_STATS_EN
   logic [31:0] stat_hits;
   logic [31:0] stat_misses;
   logic [31:0] stat_evictions;
`endif

   int checks = 0;
   int errors = 0;

   assoc_cache #(
      .DATAWIDTH    (32),
      .ADDRESSWIDTH (32),
      .WAYS         (2),
      .SETS         (16)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
`ifdef ASSOC_CACHE_STATS_EN
      ,
      .stat_hits      (stat_hits),
      .stat_misses    (stat_misses),
      .stat_evictions (stat_evictions)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic apply_reset();
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   // One request; the memory side accepts at once and returns fill in the same cycle
   task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] fill, output logic [31:0] rd, output int lat,
                       output int wb_n, output logic [31:0] wb_a, output logic [31:0] wb_d,
                       output int rf_n, output logic [31:0] rf_a);
      logic got;
      got = 1'b0; lat = -1; rd = 32'h0;
      wb_n = 0; wb_a = 32'h0; wb_d = 32'h0; rf_n = 0; rf_a = 32'h0;
      @(negedge clock);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
      @(posedge clock);
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge clock);
         req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
         if (rsp_valid) begin
            got = 1'b1; rd = rsp_rdata; lat = c + 1;
         end else if (mem_valid && mem_write) begin
            wb_n++; wb_a = mem_addr; wb_d = mem_wdata; mem_ready = 1'b1;
         end else if (mem_valid) begin
            rf_n++; rf_a = mem_addr; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = fill;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({req_ready, rsp_valid, mem_valid, mem_write} !== 4'b1000) begin
         errors++; $display("FAIL reset_ctrl got %b exp 1000", {req_ready, rsp_valid, mem_valid, mem_write});
      end
      checks++;
      if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
      checks++;
      if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
      checks++;
      if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
   endtask

   task automatic test_miss_hit();
      logic [31:0] rd, wa, wdv, ra; int lat, wn, rn;
      apply_reset();
      xact(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (rn !== 1 || ra !== 32'h40 || wn !== 0) begin
         errors++; $display("FAIL miss_refill got rn=%0d addr=%h wn=%0d exp 1 00000040 0", rn, ra, wn);
      end
      checks++;
      if (rd !== 32'hDEAD_BEEF || lat !== 3) begin
         errors++; $display("FAIL miss_rdata got %h lat %0d exp deadbeef lat 3", rd, lat);
      end
      xact(1'b0, 32'h40, 32'h0, 32'hBAD0_0000, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (rd !== 32'hDEAD_BEEF || lat !== 2 || rn + wn !== 0) begin
         errors++; $display("FAIL hit_read got %h lat %0d mem %0d exp deadbeef lat 2 mem 0", rd, lat, rn + wn);
      end
   endtask

   // Continues from test_miss_hit state: 0x40 clean in way 0
   task automatic test_writeback();
      logic [31:0] rd, wa, wdv, ra; int lat, wn, rn;
      xact(1'b1, 32'h40, 32'h1234_5678, 32'h0, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (lat !== 2 || rn + wn !== 0) begin
         errors++; $display("FAIL write_hit got lat %0d mem %0d exp lat 2 mem 0", lat, rn + wn);
      end
      xact(1'b0, 32'h440, 32'h0, 32'h4444_0000, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (rd !== 32'h4444_0000 || ra !== 32'h440 || wn !== 0) begin
         errors++; $display("FAIL fill_440 got %h addr %h wn %0d exp 44440000 00000440 0", rd, ra, wn);
      end
      xact(1'b0, 32'h840, 32'h0, 32'h8888_0000, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (wn !== 1 || wa !== 32'h40 || wdv !== 32'h1234_5678) begin
         errors++; $display("FAIL evict_wb got n=%0d addr=%h data=%h exp 1 00000040 12345678", wn, wa, wdv);
      end
      checks++;
      if (rn !== 1 || ra !== 32'h840 || rd !== 32'h8888_0000 || lat !== 4) begin
         errors++; $display("FAIL evict_refill got addr=%h data=%h lat=%0d exp 00000840 88880000 4", ra, rd, lat);
      end
`ifdef ASSOC_CACHE_STATS_EN
      checks++;
      if ({stat_hits, stat_misses, stat_evictions} !== {32'd2, 32'd3, 32'd1}) begin
         errors++; $display("FAIL stats got %0d/%0d/%0d exp 2/3/1", stat_hits, stat_misses, stat_evictions);
      end
`endif
      xact(1'b0, 32'h440, 32'h0, 32'hBAD0_0000, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (rd !== 32'h4444_0000 || lat !== 2) begin
         errors++; $display("FAIL back_to_back_hit got %h lat %0d exp 44440000 lat 2", rd, lat);
      end
   endtask

   task automatic test_lru();
      logic [31:0] rd, wa, wdv, ra; int lat, wn, rn;
      apply_reset();
      xact(1'b0, 32'h40,  32'h0, 32'hAAAA_0040, rd, lat, wn, wa, wdv, rn, ra);
      xact(1'b0, 32'h440, 32'h0, 32'hBBBB_0440, rd, lat, wn, wa, wdv, rn, ra);
      xact(1'b0, 32'h40,  32'h0, 32'hBAD0_0000, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (rd !== 32'hAAAA_0040 || lat !== 2) begin
         errors++; $display("FAIL lru_touch got %h lat %0d exp aaaa0040 lat 2", rd, lat);
      end
      xact(1'b0, 32'h840, 32'h0, 32'hCCCC_0840, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (wn !== 0 || rn !== 1 || ra !== 32'h840) begin
         errors++; $display("FAIL lru_clean_evict got wn=%0d rn=%0d addr=%h exp 0 1 00000840", wn, rn, ra);
      end
      xact(1'b0, 32'h40, 32'h0, 32'hBAD0_0000, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (rd !== 32'hAAAA_0040 || lat !== 2) begin
         errors++; $display("FAIL lru_kept got %h lat %0d exp aaaa0040 lat 2", rd, lat);
      end
      xact(1'b0, 32'h440, 32'h0, 32'hDDDD_0440, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (rn !== 1 || rd !== 32'hDDDD_0440) begin
         errors++; $display("FAIL lru_victim_gone got rn=%0d data=%h exp 1 dddd0440", rn, rd);
      end
   endtask

   task automatic test_hold();
      apply_reset();
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         checks++;
         if ({mem_valid, mem_write, req_ready, mem_addr} !== {1'b1, 1'b0, 1'b0, 32'h40}) begin
            errors++; $display("FAIL hold_cycle%0d got v=%b w=%b rdy=%b addr=%h exp 1 0 0 00000040",
                               i, mem_valid, mem_write, req_ready, mem_addr);
         end
      end
      mem_ready = 1'b1;
      @(negedge clock);
      mem_ready = 1'b0;
      checks++;
      if ({mem_valid, req_ready, rsp_valid} !== 3'b000) begin
         errors++; $display("FAIL hold_wait got %b exp 000", {mem_valid, req_ready, rsp_valid});
      end
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(negedge clock);
      mem_rvalid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL hold_rsp got v=%b data=%h exp 1 cafef00d", rsp_valid, rsp_rdata);
      end
      @(negedge clock);
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         errors++; $display("FAIL rsp_pulse got %b exp 01", {rsp_valid, req_ready});
      end
   endtask

   task automatic test_reset_wb();
      logic [31:0] rd, wa, wdv, ra; int lat, wn, rn;
      apply_reset();
      xact(1'b1, 32'h40,  32'hA5A5_A5A5, 32'h0, rd, lat, wn, wa, wdv, rn, ra);
      xact(1'b0, 32'h440, 32'h0, 32'h1111_0440, rd, lat, wn, wa, wdv, rn, ra);
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h840;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      checks++;
      if ({mem_valid, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h40, 32'hA5A5_A5A5}) begin
         errors++; $display("FAIL wb_before_reset got v=%b w=%b addr=%h data=%h exp 1 1 00000040 a5a5a5a5",
                            mem_valid, mem_write, mem_addr, mem_wdata);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({mem_valid, req_ready, rsp_valid} !== 3'b010) begin
         errors++; $display("FAIL async_reset got %b exp 010", {mem_valid, req_ready, rsp_valid});
      end
      @(negedge clock);
      reset = 1'b1;
      xact(1'b0, 32'h40, 32'h0, 32'h0F0F_0F0F, rd, lat, wn, wa, wdv, rn, ra);
      checks++;
      if (rn !== 1 || wn !== 0 || ra !== 32'h40 || rd !== 32'h0F0F_0F0F) begin
         errors++; $display("FAIL miss_after_reset got rn=%0d wn=%0d addr=%h data=%h exp 1 0 00000040 0f0f0f0f",
                            rn, wn, ra, rd);
      end
   endtask

   initial begin
      test_reset();
      test_miss_hit();
      test_writeback();
      test_lru();
      test_hold();
      test_reset_wb();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
